// File: rtl/regs_file_xys.sv
// 6502 X/Y/S index and stack register file with wired-AND SB bus resolution,
// SB hold latch, S-to-ADL drive and a saturating SB contention counter.
// Optional debug access port is enabled by defining REGS_DEBUG_EN.
module regs_file_xys #(
    parameter logic [7:0] S_INIT       = 8'h00,
    parameter logic [7:0] SB_PRECHARGE = 8'hFF,
    parameter int         CNT_W        = 4
) (
    input  logic             PHI0,
    input  logic             n_RES,
    input  logic             X_SB,
    input  logic             Y_SB,
    input  logic             S_SB,
    input  logic             SB_X,
    input  logic             SB_Y,
    input  logic             SB_S,
    input  logic             S_S,
    input  logic             S_ADL,
    input  logic [7:0]       SB_EXT,
    input  logic             SB_EXT_DRV,
    output logic [7:0]       SB,
    output logic             SB_FLOAT,
    output logic             SB_CONFLICT,
    output logic [7:0]       ADL,
    output logic             ADL_DRV,
`ifdef REGS_DEBUG_EN
    output logic [23:0]      DBG_REGS,
    input  logic             DBG_WE,
    input  logic [23:0]      DBG_WDATA,
`endif
    output logic [CNT_W-1:0] CONFLICT_CNT
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [7:0]       x_q, x_d;
    logic [7:0]       y_q, y_d;
    logic [7:0]       s_q, s_d;
    logic [7:0]       hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0] sb_and;
    logic [7:0] sb_bus;
    logic [2:0] n_drv;
    logic       bus_float;
    logic       bus_conflict;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sb_and = 8'hFF;
        n_drv  = 3'd0;
        if (X_SB)       begin sb_and = sb_and & x_q;    n_drv = n_drv + 3'd1; end
        if (Y_SB)       begin sb_and = sb_and & y_q;    n_drv = n_drv + 3'd1; end
        if (S_SB)       begin sb_and = sb_and & s_q;    n_drv = n_drv + 3'd1; end
        if (SB_EXT_DRV) begin sb_and = sb_and & SB_EXT; n_drv = n_drv + 3'd1; end
        bus_float = (n_drv == 3'd0);
        sb_bus    = bus_float ? hold_q : sb_and;
        // A lone driver always equals the AND, so this only fires with two or more.
        bus_conflict = (X_SB && (x_q != sb_and)) || (Y_SB && (y_q != sb_and)) ||
                       (S_SB && (s_q != sb_and)) || (SB_EXT_DRV && (SB_EXT != sb_and));
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        s_d    = s_q;
        hold_d = bus_float ? hold_q : sb_and;
        cnt_d  = (bus_conflict && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;
        if (SB_X) x_d = sb_bus;
        if (SB_Y) y_d = sb_bus;
        if (SB_S)     s_d = sb_bus;
        else if (S_S) s_d = s_q;
`ifdef REGS_DEBUG_EN
        if (DBG_WE) {s_d, y_d, x_d} = DBG_WDATA;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            x_q    <= 8'h00;
            y_q    <= 8'h00;
            s_q    <= S_INIT;
            hold_q <= SB_PRECHARGE;
            cnt_q  <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            s_q    <= s_d;
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
        end
    end

    // Reset forces the bus-facing outputs to their idle values even while strobes are active.
    assign SB           = n_RES ? sb_bus : SB_PRECHARGE;
    assign SB_FLOAT     = !n_RES || bus_float;
    assign SB_CONFLICT  = n_RES && bus_conflict;
    assign ADL          = (n_RES && S_ADL) ? s_q : SB_PRECHARGE;
    assign ADL_DRV      = n_RES && S_ADL;
    assign CONFLICT_CNT = cnt_q;

`ifdef REGS_DEBUG_EN
    assign DBG_REGS = {s_q, y_q, x_q};
`endif

endmodule
